// File: rtl/hs_pkg.sv
// Shared definitions for the toggle-handshake bus receiver: defaults, counter width, FSM states.
package hs_pkg;
  localparam int HS_SYNC_STAGES_DEF = 2;
  localparam int HS_CNT_WIDTH       = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } hs_state_t;
endpackage

// File: rtl/sync_bit.sv
// Purpose: single-bit multi-flop synchroniser into the local clock domain.
// Latency: STAGES edges from input sample to output.
// Backpressure: none; samples every edge.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/hs_bus_receiver.sv
// Purpose: destination side of a two-phase req/ack bus crossing, with a registered valid/ready output.
// Latency: word visible SYNC_STAGES edges after the first edge sampling a new request level.
// Backpressure: a full output register holds off capture and the ack (STALL) unless KEEP_LATEST overwrites.
module hs_bus_receiver
  import hs_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 16,
  parameter int                    SYNC_STAGES     = HS_SYNC_STAGES_DEF,
  parameter logic [DATA_WIDTH-1:0] OUT_RESET_VALUE = '0,
  parameter bit                    KEEP_LATEST     = 1'b0
) (
  input  logic                    i_dest_clk,
  input  logic                    i_d_rst,
  input  logic                    i_a_req,
  input  logic [DATA_WIDTH-1:0]   i_a_data,
  output logic                    o_d_ack,
  output logic                    o_d_valid,
  output logic [DATA_WIDTH-1:0]   o_d_data,
  input  logic                    i_d_ready,
  output logic                    o_d_stall,
  output logic [HS_CNT_WIDTH-1:0] o_d_xfer_cnt
);

  logic      req_s;
  logic      req_seen;
  logic      pending;
  logic      slot_free;
  logic      capture;
  hs_state_t state;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk (i_dest_clk),
    .rst (i_d_rst),
    .d   (i_a_req),
    .q   (req_s)
  );

  assign pending   = req_s ^ req_seen;
  assign slot_free = KEEP_LATEST ? 1'b1 : (!o_d_valid || i_d_ready);
  assign capture   = pending && slot_free;

  // i_a_data is not synchronised: the source holds it until it sees our ack toggle.
  always_ff @(posedge i_dest_clk or posedge i_d_rst) begin
    if (i_d_rst) begin
      state        <= IDLE;
      req_seen     <= 1'b0;
      o_d_valid    <= 1'b0;
      o_d_data     <= OUT_RESET_VALUE;
      o_d_ack      <= 1'b0;
      o_d_stall    <= 1'b0;
      o_d_xfer_cnt <= '0;
    end else begin
      if (capture) begin
        o_d_data     <= i_a_data;
        o_d_valid    <= 1'b1;
        req_seen     <= req_s;
        o_d_ack      <= ~o_d_ack;
        o_d_xfer_cnt <= o_d_xfer_cnt + 1'b1;
      end else if (o_d_valid && i_d_ready) begin
        o_d_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pending && !slot_free) begin
            state     <= STALL;
            o_d_stall <= 1'b1;
          end
        end
        STALL: begin
          if (slot_free) begin
            state     <= IDLE;
            o_d_stall <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          o_d_stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hs_bus_receiver.sv
// Bench for hs_bus_receiver: directed scenarios plus a randomized two-clock source/sink run.
`timescale 1ns/1ns
module tb_hs_bus_receiver;
  localparam logic [15:0] RST_VAL0 = 16'hDEAD;
  localparam int          NWORDS   = 1000;

  logic clk = 1'b0;
  logic src_clk = 1'b0;
  logic rst = 1'b1;
  int   src_half = 5;

  logic        req0 = 1'b0, rdy0 = 1'b0;
  logic [15:0] dat0 = '0;
  logic        ack0, vld0, stall0;
  logic [15:0] out0, cnt0;

  logic        req1 = 1'b0, rdy1 = 1'b0;
  logic [15:0] dat1 = '0;
  logic        ack1, vld1, stall1;
  logic [15:0] out1, cnt1;

  int errors = 0;
  int checks = 0;

  logic [15:0] sent[$];
  logic [15:0] rx[$];

  always #6 clk = ~clk;
  always #(src_half) src_clk = ~src_clk;

  hs_bus_receiver #(
    .DATA_WIDTH(16), .SYNC_STAGES(2), .OUT_RESET_VALUE(RST_VAL0), .KEEP_LATEST(1'b0)
  ) dut0 (
    .i_dest_clk(clk), .i_d_rst(rst), .i_a_req(req0), .i_a_data(dat0),
    .o_d_ack(ack0), .o_d_valid(vld0), .o_d_data(out0), .i_d_ready(rdy0),
    .o_d_stall(stall0), .o_d_xfer_cnt(cnt0)
  );

  hs_bus_receiver #(
    .DATA_WIDTH(16), .SYNC_STAGES(2), .OUT_RESET_VALUE(16'h0000), .KEEP_LATEST(1'b1)
  ) dut1 (
    .i_dest_clk(clk), .i_d_rst(rst), .i_a_req(req1), .i_a_data(dat1),
    .o_d_ack(ack1), .o_d_valid(vld1), .o_d_data(out1), .i_d_ready(rdy1),
    .o_d_stall(stall1), .o_d_xfer_cnt(cnt1)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0; rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", vld0); end
    checks++; if (out0 !== RST_VAL0) begin errors++; $display("FAIL reset_data: got %h want %h", out0, RST_VAL0); end
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack0); end
    checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall0); end
    checks++; if (cnt0 !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt0); end
    checks++; if (out1 !== 16'h0000 || vld1 !== 1'b0) begin errors++; $display("FAIL reset_kl: got data %h valid %b want 0000 0", out1, vld1); end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_single();
    do_reset();
    rdy0 = 1'b1; dat0 = 16'hA5C3; req0 = 1'b1;
    step(2);
    checks++; if (vld0 !== 1'b0 || ack0 !== 1'b0) begin errors++; $display("FAIL single_early: got valid %b ack %b want 0 0", vld0, ack0); end
    step(1);
    checks++; if (vld0 !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", vld0); end
    checks++; if (out0 !== 16'hA5C3) begin errors++; $display("FAIL single_data: got %h want a5c3", out0); end
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL single_ack: got %b want 1", ack0); end
    checks++; if (cnt0 !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", cnt0); end
    step(1);
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL single_drop: got %b want 0", vld0); end
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy0 = 1'b0; dat0 = 16'h0001; req0 = 1'b1;
    step(3);
    checks++; if (vld0 !== 1'b1 || out0 !== 16'h0001 || ack0 !== 1'b1) begin
      errors++; $display("FAIL bp_first: got valid %b data %h ack %b want 1 0001 1", vld0, out0, ack0); end
    dat0 = 16'h0002; req0 = 1'b0;
    step(2);
    checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL bp_stall_early: got %b want 0", stall0); end
    step(1);
    checks++; if (stall0 !== 1'b1) begin errors++; $display("FAIL bp_stall_edge: got %b want 1", stall0); end
    step(4);
    checks++; if (stall0 !== 1'b1 || ack0 !== 1'b1 || out0 !== 16'h0001 || cnt0 !== 16'd1) begin
      errors++; $display("FAIL bp_hold: got stall %b ack %b data %h cnt %0d want 1 1 0001 1", stall0, ack0, out0, cnt0); end
    rdy0 = 1'b1;
    step(1);
    checks++; if (vld0 !== 1'b1 || out0 !== 16'h0002) begin errors++; $display("FAIL bp_swap: got valid %b data %h want 1 0002", vld0, out0); end
    checks++; if (ack0 !== 1'b0 || stall0 !== 1'b0 || cnt0 !== 16'd2) begin
      errors++; $display("FAIL bp_release: got ack %b stall %b cnt %0d want 0 0 2", ack0, stall0, cnt0); end
    step(1);
    checks++; if (vld0 !== 1'b0 || ack0 !== 1'b0) begin errors++; $display("FAIL bp_drain: got valid %b ack %b want 0 0", vld0, ack0); end
  endtask

  task automatic test_keep_latest();
    logic [15:0] words [3];
    logic        exp_ack;
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    do_reset();
    rdy1 = 1'b0;
    for (int w = 0; w < 3; w++) begin
      dat1 = words[w]; req1 = ~req1;
      for (int s = 0; s < 3; s++) begin
        step(1);
        checks++; if (stall1 !== 1'b0) begin errors++; $display("FAIL kl_stall: got %b want 0", stall1); end
      end
      exp_ack = (w % 2 == 0);
      checks++; if (ack1 !== exp_ack || out1 !== words[w]) begin
        errors++; $display("FAIL kl_word: got ack %b data %h want %b %h", ack1, out1, exp_ack, words[w]); end
    end
    checks++; if (out1 !== 16'h3333 || vld1 !== 1'b1) begin errors++; $display("FAIL kl_final: got data %h valid %b want 3333 1", out1, vld1); end
    checks++; if (cnt1 !== 16'd3) begin errors++; $display("FAIL kl_cnt: got %0d want 3", cnt1); end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_cnt;
    do_reset();
    exp_cnt = 16'hFFFF;
    force dut0.o_d_xfer_cnt = 16'hFFFF;
    step(1);
    release dut0.o_d_xfer_cnt;
    rdy0 = 1'b1; dat0 = 16'h5A5A; req0 = 1'b1;
    step(3);
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (cnt0 !== exp_cnt) begin errors++; $display("FAIL wrap_cnt: got %h want %h", cnt0, exp_cnt); end
    checks++; if (out0 !== 16'h5A5A || ack0 !== 1'b1) begin errors++; $display("FAIL wrap_data: got data %h ack %b want 5a5a 1", out0, ack0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rdy0 = 1'b1; dat0 = 16'hBEEF; req0 = 1'b1;
    step(1);
    rst = 1'b1;
    step(1);
    checks++; if (vld0 !== 1'b0 || ack0 !== 1'b0 || cnt0 !== 16'd0 || out0 !== RST_VAL0 || stall0 !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got valid %b ack %b cnt %0d data %h stall %b want reset values", vld0, ack0, cnt0, out0, stall0); end
    rst = 1'b0;
    step(2);
    checks++; if (vld0 !== 1'b0 || ack0 !== 1'b0) begin errors++; $display("FAIL mid_early: got valid %b ack %b want 0 0", vld0, ack0); end
    step(1);
    checks++; if (vld0 !== 1'b1 || out0 !== 16'hBEEF || ack0 !== 1'b1 || cnt0 !== 16'd1) begin
      errors++; $display("FAIL mid_capture: got valid %b data %h ack %b cnt %0d want 1 beef 1 1", vld0, out0, ack0, cnt0); end
    step(3);
    checks++; if (ack0 !== 1'b1 || cnt0 !== 16'd1) begin errors++; $display("FAIL mid_single: got ack %b cnt %0d want 1 1", ack0, cnt0); end
  endtask

  task automatic src_proc(input int n);
    logic a1, a2;
    int   waited;
    a1 = ack0; a2 = ack0;
    for (int w = 0; w < n; w++) begin
      if (w % 100 == 0) src_half = int'($urandom_range(2, 18));
      waited = 0;
      while (a2 !== req0 && waited < 4000) begin
        @(posedge src_clk);
        a2 = a1; a1 = ack0; waited++;
      end
      if (waited >= 4000) begin
        errors++; checks++;
        $display("FAIL rand_ack_timeout: word %0d got no ack within %0d source cycles", w, waited);
        break;
      end
      @(posedge src_clk);
      dat0 = 16'($urandom);
      req0 = ~req0;
      sent.push_back(dat0);
    end
  endtask

  task automatic sink_proc(input int n);
    int cyc;
    cyc = 0;
    while (rx.size() < n && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      rdy0 = ($urandom_range(0, 3) != 0);
      if (vld0 && rdy0) rx.push_back(out0);
    end
  endtask

  task automatic test_random();
    int n;
    do_reset();
    sent.delete(); rx.delete();
    fork
      src_proc(NWORDS);
      sink_proc(NWORDS);
    join
    step(2);
    checks++; if (rx.size() != NWORDS || sent.size() != NWORDS) begin
      errors++; $display("FAIL rand_count: got %0d received of %0d sent want %0d", rx.size(), sent.size(), NWORDS); end
    n = (rx.size() < sent.size()) ? rx.size() : sent.size();
    for (int i = 0; i < n; i++) begin
      checks++; if (rx[i] !== sent[i]) begin errors++; $display("FAIL rand_word %0d: got %h want %h", i, rx[i], sent[i]); end
    end
    checks++; if (cnt0 !== 16'(NWORDS)) begin errors++; $display("FAIL rand_cnt: got %0d want %0d", cnt0, NWORDS); end
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL rand_ack_parity: got %b want 0", ack0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_keep_latest();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
